// File: rtl/auction_pkg.sv
`default_nettype none
// ============================================================================
// Module      : auction_pkg
// Description : Shared types and constants for the sequential auction
//               controller. It holds the FSM state encoding, the default
//               bidder-count and bid-width constants, and the bid/bidder
//               typedefs.
// Revision    : 1.0  initial release
// ============================================================================
package auction_pkg;

    // Default log2(bidder count) and bid width.
    localparam int C_DEFAULT_N = 2;
    localparam int C_DEFAULT_W = 2;

    // Controller state. The encoding is explicit so that any state register
    // built from this type has a fixed 2-bit width.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EVAL    = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Bid value and bidder index at the default widths.
    typedef logic [C_DEFAULT_W-1:0] bid_t;
    typedef logic [C_DEFAULT_N-1:0] bidder_t;

endpackage : auction_pkg
`default_nettype wire

// File: rtl/auction_bid_store.sv
`default_nettype none
// ============================================================================
// Module      : auction_bid_store
// Description : Register file of 2**N bid slots, each W bits wide, plus a
//               per-slot "submitted" mask. It has one write port, one
//               combinational indexed read port and a synchronous clear.
//               Clear has priority over write.
// Ports       : clk, rst_n         clock and asynchronous active-low reset
//               clear              zero every slot and the mask
//               wr_en/wr_id/
//               wr_value           store wr_value in slot wr_id and mark it
//               rd_idx             slot to read
//               rd_value/rd_valid  slot contents and its mask bit
// Revision    : 1.0  initial release
// ============================================================================
module auction_bid_store
    import auction_pkg::*;
#(
    parameter int N = C_DEFAULT_N,
    parameter int W = C_DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         wr_en,
    input  logic [N-1:0] wr_id,
    input  logic [W-1:0] wr_value,
    input  logic [N-1:0] rd_idx,
    output logic [W-1:0] rd_value,
    output logic         rd_valid
);

    localparam int C_SLOTS = 2 ** N;

    logic [W-1:0]       r_slot [C_SLOTS];
    logic [C_SLOTS-1:0] r_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < C_SLOTS; i++) begin
                r_slot[i] <= '0;
            end
            r_mask <= '0;
        end else if (clear) begin
            for (int i = 0; i < C_SLOTS; i++) begin
                r_slot[i] <= '0;
            end
            r_mask <= '0;
        end else if (wr_en) begin
            // A repeat bid from the same bidder simply overwrites its slot.
            r_slot[wr_id] <= wr_value;
            r_mask[wr_id] <= 1'b1;
        end
    end

    always_comb begin
        rd_value = r_slot[rd_idx];
        rd_valid = r_mask[rd_idx];
    end

endmodule : auction_bid_store
`default_nettype wire

// File: rtl/auction_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : auction_ctrl
// Description : Sequential auction controller. It collects bids from 2**N
//               bidders over a valid/ready channel and stores them in
//               auction_bid_store. It then scans the slots with a single
//               comparator, one slot per clock, and holds the result on a
//               valid/ready output channel until it is consumed.
//               Build option: define AUCTION_SECOND_PRICE_EN for
//               second-price (Vickrey) pricing. In the default build the
//               price equals the winning bid.
// Ports       : clk, rst_n                 clock and asynchronous active-low reset
//               start                      open a round (IDLE only)
//               bid_valid/bid_ready/
//               bid_id/bid_value           bid channel (COLLECT only)
//               close                      end collection (COLLECT only)
//               busy                       round in progress
//               res_valid/res_ready        result channel (DONE only)
//               winner/winning_bid/price/
//               no_bids                    registered result
// Revision    : 1.0  initial release
// ============================================================================
module auction_ctrl
    import auction_pkg::*;
#(
    parameter int N = C_DEFAULT_N,
    parameter int W = C_DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         bid_valid,
    output logic         bid_ready,
    input  logic [N-1:0] bid_id,
    input  logic [W-1:0] bid_value,
    input  logic         close,
    output logic         busy,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] winner,
    output logic [W-1:0] winning_bid,
    output logic [W-1:0] price,
    output logic         no_bids
);

    localparam int           C_SLOTS    = 2 ** N;
    localparam logic [N-1:0] C_LAST_IDX = N'(C_SLOTS - 1);

    state_t       r_state;
    state_t       w_state_nxt;

    logic [N-1:0] r_idx;
    logic         r_best_vld;
    logic [N-1:0] r_best_id;
    logic [W-1:0] r_best_val;
`ifdef AUCTION_SECOND_PRICE_EN
    logic         r_sec_vld;
    logic [W-1:0] r_sec_val;
`endif

    logic         r_res_valid;
    logic [N-1:0] r_winner;
    logic [W-1:0] r_winning_bid;
    logic [W-1:0] r_price;
    logic         r_no_bids;

    logic         w_clear;
    logic         w_bid_fire;
    logic         w_take_result;
    logic [W-1:0] w_rd_value;
    logic         w_rd_valid;

    assign w_clear       = (r_state == IDLE) && start;
    assign w_bid_fire    = (r_state == COLLECT) && bid_valid;
    assign w_take_result = r_res_valid && res_ready;

    auction_bid_store #(
        .N (N),
        .W (W)
    ) u_store (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (w_clear),
        .wr_en    (w_bid_fire),
        .wr_id    (bid_id),
        .wr_value (bid_value),
        .rd_idx   (r_idx),
        .rd_value (w_rd_value),
        .rd_valid (w_rd_valid)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        bid_ready   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                bid_ready = 1'b1;
                if (close) begin
                    w_state_nxt = EVAL;
                end
            end
            EVAL: begin
                if (r_idx == C_LAST_IDX) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (w_take_result) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Scan: one slot per EVAL cycle through the shared comparator.
    // Candidates are cleared when collection closes, so a round never
    // inherits state from the previous one.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_best_vld <= 1'b0;
            r_best_id  <= '0;
            r_best_val <= '0;
`ifdef AUCTION_SECOND_PRICE_EN
            r_sec_vld  <= 1'b0;
            r_sec_val  <= '0;
`endif
        end else begin
            case (r_state)
                COLLECT: begin
                    if (close) begin
                        r_idx      <= '0;
                        r_best_vld <= 1'b0;
                        r_best_id  <= '0;
                        r_best_val <= '0;
`ifdef AUCTION_SECOND_PRICE_EN
                        r_sec_vld  <= 1'b0;
                        r_sec_val  <= '0;
`endif
                    end
                end
                EVAL: begin
                    // The index wraps to 0 after the last slot.
                    r_idx <= r_idx + N'(1);
                    if (w_rd_valid) begin
                        // Strictly greater: on a tie the earlier (lower)
                        // index keeps the lead.
                        if (!r_best_vld || (w_rd_value > r_best_val)) begin
                            r_best_vld <= 1'b1;
                            r_best_id  <= r_idx;
                            r_best_val <= w_rd_value;
`ifdef AUCTION_SECOND_PRICE_EN
                            r_sec_vld  <= r_best_vld;
                            r_sec_val  <= r_best_val;
                        end else if (!r_sec_vld || (w_rd_value > r_sec_val)) begin
                            // Catches ties with the leader too, so that
                            // equal top bids clear at the top price.
                            r_sec_vld  <= 1'b1;
                            r_sec_val  <= w_rd_value;
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Result register. It loads on the first DONE cycle and holds until
    // the handshake, then returns to zero.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid   <= 1'b0;
            r_winner      <= '0;
            r_winning_bid <= '0;
            r_price       <= '0;
            r_no_bids     <= 1'b0;
        end else if ((r_state == DONE) && !r_res_valid) begin
            r_res_valid   <= 1'b1;
            r_winner      <= r_best_id;
            r_winning_bid <= r_best_val;
            r_no_bids     <= !r_best_vld;
`ifdef AUCTION_SECOND_PRICE_EN
            r_price       <= r_sec_vld ? r_sec_val : '0;
`else
            r_price       <= r_best_val;
`endif
        end else if (w_take_result) begin
            r_res_valid   <= 1'b0;
            r_winner      <= '0;
            r_winning_bid <= '0;
            r_price       <= '0;
            r_no_bids     <= 1'b0;
        end
    end

    assign res_valid   = r_res_valid;
    assign winner      = r_winner;
    assign winning_bid = r_winning_bid;
    assign price       = r_price;
    assign no_bids     = r_no_bids;

endmodule : auction_ctrl
`default_nettype wire

// File: tb/tb_auction_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_auction_ctrl
// Description : Self-checking bench for auction_ctrl (N=2, W=8). It keeps a
//               reference model of the bid book and derives expected
//               results by sorting the submitted values. When
//               AUCTION_SECOND_PRICE_EN is defined, it expects Vickrey
//               pricing.
// Revision    : 1.0  initial release
// ============================================================================
module tb_auction_ctrl;

    localparam int N     = 2;
    localparam int W     = 8;
    localparam int SLOTS = 4;
    localparam int LAT   = 1 + SLOTS;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         bid_valid;
    logic         bid_ready;
    logic [N-1:0] bid_id;
    logic [W-1:0] bid_value;
    logic         close;
    logic         busy;
    logic         res_valid;
    logic         res_ready;
    logic [N-1:0] winner;
    logic [W-1:0] winning_bid;
    logic [W-1:0] price;
    logic         no_bids;

    auction_ctrl #(.N(N), .W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .bid_valid   (bid_valid),
        .bid_ready   (bid_ready),
        .bid_id      (bid_id),
        .bid_value   (bid_value),
        .close       (close),
        .busy        (busy),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .winner      (winner),
        .winning_bid (winning_bid),
        .price       (price),
        .no_bids     (no_bids)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference bid book.
    logic [W-1:0] m_val  [SLOTS];
    bit           m_mask [SLOTS];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < SLOTS; i++) begin
            m_val[i]  = '0;
            m_mask[i] = 1'b0;
        end
    endtask

    // Expected result: sort the submitted values in descending order. The
    // top value is the winning bid, and the lowest bidder holding it wins.
    task automatic model_expect(output logic [N+2*W:0] exp);
        int           q[$];
        logic [N-1:0] ew;
        logic [W-1:0] eb;
        logic [W-1:0] ep;
        logic         en;
        q  = {};
        ew = '0;
        eb = '0;
        ep = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (m_mask[i]) q.push_back(int'(m_val[i]));
        end
        en = (q.size() == 0);
        if (!en) begin
            q.rsort();
            eb = W'(q[0]);
            for (int i = SLOTS - 1; i >= 0; i--) begin
                if (m_mask[i] && (m_val[i] == eb)) ew = N'(i);
            end
`ifdef AUCTION_SECOND_PRICE_EN
            ep = (q.size() > 1) ? W'(q[1]) : '0;
`else
            ep = eb;
`endif
        end
        exp = {ew, eb, ep, en};
    endtask

    task automatic start_round();
        start = 1'b1;
        tick();
        start = 1'b0;
        model_clear();
    endtask

    task automatic send_bid(input int id, input int val, input bit with_close);
        bid_valid = 1'b1;
        bid_id    = N'(id);
        bid_value = W'(val);
        close     = with_close;
        tick();
        bid_valid = 1'b0;
        close     = 1'b0;
        m_val[id]  = W'(val);
        m_mask[id] = 1'b1;
    endtask

    // Returns the number of edges from the close edge until res_valid is seen.
    task automatic wait_result(output int lat);
        lat = 0;
        while ((res_valid !== 1'b1) && (lat < 40)) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        if ({bid_ready, busy, res_valid, winner, winning_bid, price, no_bids} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got rdy=%b busy=%b rv=%b w=%0d bid=%0d price=%0d nb=%b, want all 0",
                     bid_ready, busy, res_valid, winner, winning_bid, price, no_bids);
        end
        n_cmp++;
        rst_n = 1'b1;
        tick();
    endtask

    // The directed rounds of the test plan: mixed bids, a tie, an empty
    // round, and an overwrite.
    task automatic test_plan_rounds();
        int            nb  [4] = '{4, 2, 0, 3};
        int            ids [4][4];
        int            vals[4][4];
        int            lat;
        logic [N+2*W:0] exp;
        ids[0] = '{0, 1, 2, 3};  vals[0] = '{10, 40, 25, 5};
        ids[1] = '{2, 3, 0, 0};  vals[1] = '{30, 30, 0, 0};
        ids[2] = '{0, 0, 0, 0};  vals[2] = '{0, 0, 0, 0};
        ids[3] = '{0, 0, 1, 0};  vals[3] = '{50, 7, 9, 0};
        for (int r = 0; r < 4; r++) begin
            start_round();
            if ({bid_ready, busy} !== 2'b11) begin
                n_bad++;
                $display("FAIL plan%0d_collect: got rdy=%b busy=%b, want 1 1", r, bid_ready, busy);
            end
            n_cmp++;
            for (int k = 0; k < nb[r]; k++) send_bid(ids[r][k], vals[r][k], 1'b0);
            close = 1'b1;
            tick();
            close = 1'b0;
            wait_result(lat);
            if (lat != LAT) begin
                n_bad++;
                $display("FAIL plan%0d_latency: got %0d cycles, want %0d", r, lat, LAT);
            end
            n_cmp++;
            model_expect(exp);
            if ({winner, winning_bid, price, no_bids} !== exp) begin
                n_bad++;
                $display("FAIL plan%0d_result: got w=%0d bid=%0d price=%0d nb=%b, want w=%0d bid=%0d price=%0d nb=%b",
                         r, winner, winning_bid, price, no_bids,
                         exp[N+2*W:2*W+1], exp[2*W:W+1], exp[W:1], exp[0]);
            end
            n_cmp++;
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            if ({res_valid, busy, winner, winning_bid, price, no_bids} !== '0) begin
                n_bad++;
                $display("FAIL plan%0d_release: got rv=%b busy=%b w=%0d bid=%0d price=%0d nb=%b, want all 0",
                         r, res_valid, busy, winner, winning_bid, price, no_bids);
            end
            n_cmp++;
        end
    endtask

    // The result must hold under backpressure, and start must be ignored
    // while the result is pending.
    task automatic test_hold();
        int            lat;
        logic [N+2*W:0] exp;
        start_round();
        send_bid(0, 3, 1'b0);
        send_bid(1, 99, 1'b0);
        send_bid(2, 99, 1'b1);
        wait_result(lat);
        model_expect(exp);
        for (int c = 0; c < 10; c++) begin
            start = 1'b1;
            tick();
            if ({res_valid, busy, winner, winning_bid, price, no_bids} !== {2'b11, exp}) begin
                n_bad++;
                $display("FAIL hold_c%0d: got rv=%b busy=%b w=%0d bid=%0d price=%0d nb=%b, want rv=1 busy=1 w=%0d bid=%0d price=%0d nb=%b",
                         c, res_valid, busy, winner, winning_bid, price, no_bids,
                         exp[N+2*W:2*W+1], exp[2*W:W+1], exp[W:1], exp[0]);
            end
            n_cmp++;
        end
        start     = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        if ({res_valid, busy, bid_ready} !== 3'b000) begin
            n_bad++;
            $display("FAIL hold_release: got rv=%b busy=%b rdy=%b, want 0 0 0", res_valid, busy, bid_ready);
        end
        n_cmp++;
    endtask

    // Reset in the middle of EVAL aborts the round and leaves no stale bids.
    task automatic test_reset_mid_eval();
        int            lat;
        logic [N+2*W:0] exp;
        start_round();
        send_bid(0, 200, 1'b0);
        send_bid(1, 150, 1'b0);
        send_bid(2, 100, 1'b1);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        if ({res_valid, busy, bid_ready} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_mid_eval: got rv=%b busy=%b rdy=%b, want 0 0 0", res_valid, busy, bid_ready);
        end
        n_cmp++;
        #1;
        rst_n = 1'b1;
        tick();
        model_clear();
        start_round();
        send_bid(3, 1, 1'b1);
        wait_result(lat);
        model_expect(exp);
        if ((lat != LAT) || ({winner, winning_bid, price, no_bids} !== exp)) begin
            n_bad++;
            $display("FAIL post_reset_round: got lat=%0d w=%0d bid=%0d price=%0d nb=%b, want lat=%0d w=%0d bid=%0d price=%0d nb=%b",
                     lat, winner, winning_bid, price, no_bids, LAT,
                     exp[N+2*W:2*W+1], exp[2*W:W+1], exp[W:1], exp[0]);
        end
        n_cmp++;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    // Random rounds. Each round starts with stray bid/close traffic in
    // IDLE, and the final bid of each round shares its cycle with close.
    task automatic test_random();
        int            lat;
        int            nbids;
        int            id;
        int            val;
        logic [N+2*W:0] exp;
        for (int r = 0; r < 25; r++) begin
            bid_valid = 1'b1;
            bid_id    = N'($urandom_range(0, SLOTS - 1));
            bid_value = W'($urandom_range(0, 255));
            close     = 1'b1;
            tick();
            bid_valid = 1'b0;
            close     = 1'b0;
            if ({busy, bid_ready} !== 2'b00) begin
                n_bad++;
                $display("FAIL rand%0d_idle: got busy=%b rdy=%b, want 0 0", r, busy, bid_ready);
            end
            n_cmp++;
            start_round();
            nbids = $urandom_range(0, 6);
            for (int k = 0; k < nbids; k++) begin
                id  = $urandom_range(0, SLOTS - 1);
                val = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 255);
                send_bid(id, val, (k == nbids - 1));
            end
            if (nbids == 0) begin
                close = 1'b1;
                tick();
                close = 1'b0;
            end
            wait_result(lat);
            model_expect(exp);
            if ((lat != LAT) || ({winner, winning_bid, price, no_bids} !== exp)) begin
                n_bad++;
                $display("FAIL rand%0d_result: got lat=%0d w=%0d bid=%0d price=%0d nb=%b, want lat=%0d w=%0d bid=%0d price=%0d nb=%b",
                         r, lat, winner, winning_bid, price, no_bids, LAT,
                         exp[N+2*W:2*W+1], exp[2*W:W+1], exp[W:1], exp[0]);
            end
            n_cmp++;
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        bid_valid = 1'b0;
        bid_id    = '0;
        bid_value = '0;
        close     = 1'b0;
        res_ready = 1'b0;
        model_clear();
        test_reset();
        test_plan_rounds();
        test_hold();
        test_reset_mid_eval();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_auction_ctrl
`default_nettype wire
